// File: rtl/mult_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mult_seq_pkg
// Purpose  : Shared types and widths for the 32x32 multiplier operand
//            sequencer: operand/product widths, the operand-pair struct
//            carried through the FIFO, and the sequencer FSM state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package mult_seq_pkg;

    localparam int OP_W   = 32;
    localparam int PROD_W = 64;

    // One multiplication job as it travels through the operand FIFO.
    typedef struct packed {
        logic [OP_W-1:0] a;
        logic [OP_W-1:0] b;
    } opnd_pair_t;

    // Sequencer FSM: one job at a time, start pulse, then follow mult_busy
    // high and back low before capturing the product.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT_HI = 3'd2,
        ST_WAIT_LO = 3'd3,
        ST_DONE    = 3'd4
    } seq_state_e;

endpackage : mult_seq_pkg
`default_nettype wire

// File: rtl/mult_seq_fifo.sv
`default_nettype none
// ============================================================================
// Module   : mult_seq_fifo
// Purpose  : Synchronous FIFO of operand pairs. Pushes are ignored when
//            full and pops are ignored when empty, so a full FIFO never
//            accepts a push even if a pop happens in the same cycle.
//            FIFO_DEPTH must be a power of two so pointers wrap naturally.
// Revision : 1.0 - initial release
// ============================================================================
module mult_seq_fifo
    import mult_seq_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push_i,
    input  opnd_pair_t push_data_i,
    input  logic       pop_i,
    output opnd_pair_t pop_data_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);

    opnd_pair_t      mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;
    logic            do_push;
    logic            do_pop;

    assign full_o     = (count_q == DEPTH_CNT);
    assign empty_o    = (count_q == '0);
    assign do_push    = push_i && !full_o;
    assign do_pop     = pop_i && !empty_o;
    assign pop_data_o = mem_q[rd_ptr_q];

    // Occupancy: simultaneous push and pop leaves the count unchanged.
    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers; reset flushes the FIFO.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule : mult_seq_fifo
`default_nettype wire

// File: rtl/mult32x32_seq.sv
`default_nettype none
// ============================================================================
// Module   : mult32x32_seq
// Purpose  : Operand sequencer for an external 32x32 multiplier. Buffers
//            operand pairs in a FIFO, issues one job at a time with a
//            single-cycle start pulse, follows mult_busy high then low,
//            captures the 64-bit product and offers it on a valid/ready port.
// Options  : MULT_SEQ_ACC_EN - adds acc_clr/acc_out and a 64-bit running
//            sum of every accepted result.
// Revision : 1.0 - initial release
// ============================================================================
module mult32x32_seq
    import mult_seq_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [OP_W-1:0]   in_a,
    input  logic [OP_W-1:0]   in_b,
    output logic              in_ready,
    output logic              mult_start,
    output logic [OP_W-1:0]   mult_a,
    output logic [OP_W-1:0]   mult_b,
    input  logic              mult_busy,
    input  logic [PROD_W-1:0] mult_product,
    output logic              out_valid,
    output logic [PROD_W-1:0] out_product,
    input  logic              out_ready
`ifdef MULT_SEQ_ACC_EN
    ,
    input  logic              acc_clr,
    output logic [PROD_W-1:0] acc_out
`endif
);

    seq_state_e        state_q;
    seq_state_e        state_d;
    opnd_pair_t        push_pair;
    opnd_pair_t        head_pair;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_push;
    logic              fifo_pop;
    logic              capture_prod;
    logic              out_hs;
    logic [OP_W-1:0]   mult_a_q;
    logic [OP_W-1:0]   mult_b_q;
    logic [PROD_W-1:0] out_product_q;

    assign in_ready    = !reset && !fifo_full;
    assign fifo_push   = in_valid && in_ready;
    assign push_pair.a = in_a;
    assign push_pair.b = in_b;

    mult_seq_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (fifo_push),
        .push_data_i (push_pair),
        .pop_i       (fifo_pop),
        .pop_data_o  (head_pair),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // Both derive from the registered state, so they are glitch-free.
    assign mult_start  = (state_q == ST_ISSUE);
    assign out_valid   = (state_q == ST_DONE);
    assign out_hs      = out_valid && out_ready;
    assign mult_a      = mult_a_q;
    assign mult_b      = mult_b_q;
    assign out_product = out_product_q;

    // Next-state logic: decides when to pop a job and when to capture.
    always_comb begin
        state_d      = state_q;
        fifo_pop     = 1'b0;
        capture_prod = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT_HI;
            end
            ST_WAIT_HI: begin
                if (mult_busy) begin
                    state_d = ST_WAIT_LO;
                end
            end
            ST_WAIT_LO: begin
                if (!mult_busy) begin
                    capture_prod = 1'b1;
                    state_d      = ST_DONE;
                end
            end
            ST_DONE: begin
                // Pop straight into ISSUE so back-to-back jobs lose no cycle.
                if (out_ready) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        state_d  = ST_ISSUE;
                    end else begin
                        state_d  = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand registers change only on a pop, which only happens while the
    // multiplier is idle, so the operands are stable for the whole job.
    always_ff @(posedge clk) begin
        if (reset) begin
            mult_a_q <= '0;
            mult_b_q <= '0;
        end else if (fifo_pop) begin
            mult_a_q <= head_pair.a;
            mult_b_q <= head_pair.b;
        end
    end

    // Result register, loaded once per job and held through DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_product_q <= '0;
        end else if (capture_prod) begin
            out_product_q <= mult_product;
        end
    end

`ifdef MULT_SEQ_ACC_EN
    logic [PROD_W-1:0] acc_q;

    assign acc_out = acc_q;

    // Running sum of accepted results; a clear coinciding with a handshake
    // restarts the sum from that result.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
        end else if (out_hs) begin
            acc_q <= acc_clr ? out_product_q : (acc_q + out_product_q);
        end else if (acc_clr) begin
            acc_q <= '0;
        end
    end
`else
    logic unused_hs;
    assign unused_hs = out_hs;
`endif

endmodule : mult32x32_seq
`default_nettype wire

// File: tb/tb_mult32x32_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult32x32_seq
// Purpose  : Self-checking bench for mult32x32_seq with a behavioural
//            multiplier (random busy latency) and a queue-based result model.
// Options  : MULT_SEQ_ACC_EN - also exercises the accumulator.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult32x32_seq;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_ready;
    logic        mult_start;
    logic [31:0] mult_a;
    logic [31:0] mult_b;
    logic        mult_busy;
    logic [63:0] mult_product;
    logic        out_valid;
    logic [63:0] out_product;
    logic        out_ready;
`ifdef MULT_SEQ_ACC_EN
    logic        acc_clr;
    logic [63:0] acc_out;
`endif

    int n_checks;
    int n_fail;
    int n_results;
    int n_starts;
    logic rnd_rdy;

    // Expected products in acceptance order.
    logic [63:0] exp_q[$];

    // Multiplier model state.
    logic [31:0] cap_a;
    logic [31:0] cap_b;
    int          lat;

    // Hold-stability tracking.
    logic        prev_hold;
    logic [63:0] prev_prod;

    mult32x32_seq #(
        .FIFO_DEPTH (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_ready     (in_ready),
        .mult_start   (mult_start),
        .mult_a       (mult_a),
        .mult_b       (mult_b),
        .mult_busy    (mult_busy),
        .mult_product (mult_product),
        .out_valid    (out_valid),
        .out_product  (out_product),
        .out_ready    (out_ready)
`ifdef MULT_SEQ_ACC_EN
        ,
        .acc_clr      (acc_clr),
        .acc_out      (acc_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Behavioural multiplier: busy for 2..5 cycles after a start, product
    // is garbage while busy and becomes a*b on the edge busy falls.
    always @(posedge clk) begin
        if (reset) begin
            mult_busy    <= 1'b0;
            mult_product <= 64'd0;
            lat          <= 0;
        end else if (mult_start) begin
            cap_a        <= mult_a;
            cap_b        <= mult_b;
            mult_busy    <= 1'b1;
            lat          <= int'($urandom_range(2, 5));
            mult_product <= {$urandom, $urandom};
        end else if (mult_busy) begin
            if (lat == 1) begin
                mult_busy    <= 1'b0;
                mult_product <= 64'(cap_a) * 64'(cap_b);
            end
            lat <= lat - 1;
        end
    end

    // Monitor: reference queue, result ordering, hold and operand stability.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            prev_hold = 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                exp_q.push_back(64'(in_a) * 64'(in_b));
            end
            if (mult_start) begin
                n_starts++;
            end
            if (mult_busy) begin
                chk("operands_stable", {mult_a, mult_b}, {cap_a, cap_b});
            end
            if (prev_hold) begin
                chk("out_hold", out_product, prev_prod);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 64'(out_valid), 64'd0);
                end else begin
                    chk("result_order", out_product, exp_q.pop_front());
                end
                n_results++;
            end
            prev_hold = out_valid && !out_ready;
            prev_prod = out_product;
        end
    end

    // Offer one pair and hold it until accepted (bounded).
    task automatic send(input logic [31:0] a, input logic [31:0] b);
        bit acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        for (int i = 0; i < 300 && !acc; i++) begin
            @(negedge clk);
            if (in_ready) acc = 1'b1;
            @(posedge clk);
            #1;
            if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
        end
        in_valid = 1'b0;
        if (!acc) chk("send_timeout", 64'(acc), 64'd1);
    endtask

    // Wait for out_valid (bounded) and compare with the expected product.
    task automatic wait_result(input string tag, input logic [63:0] exp);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (out_valid) got = 1'b1;
        end
        chk({tag, "_valid"}, 64'(got), 64'd1);
        chk(tag, out_product, exp);
        @(posedge clk);
        #1;
    endtask

    // Let every queued job complete with out_ready high (bounded).
    task automatic drain();
        bit idle;
        idle      = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 500 && !idle; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_valid && !mult_busy) idle = 1'b1;
        end
        chk("drain_timeout", 64'(idle), 64'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          s0;
        int          r0;
        int          k;
        bit          bad;
        logic [31:0] bp_a [6];
        logic [31:0] bp_b [6];
        logic [31:0] ra;
        logic [31:0] rb;

        n_checks  = 0;
        n_fail    = 0;
        n_results = 0;
        n_starts  = 0;
        rnd_rdy   = 1'b0;
        prev_hold = 1'b0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
`ifdef MULT_SEQ_ACC_EN
        acc_clr   = 1'b0;
`endif

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready",    64'(in_ready),   64'd0);
        chk("rst_out_valid",   64'(out_valid),  64'd0);
        chk("rst_out_product", out_product,     64'd0);
        chk("rst_mult_ab",     {mult_a, mult_b}, 64'd0);
        chk("rst_mult_start",  64'(mult_start), 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Single job with issue-latency check.
        out_ready = 1'b1;
        s0        = n_starts;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_a     = 32'd209381649;
        in_b     = 32'd321882649;
        @(negedge clk);
        chk("single_accept", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("start_n0", 64'(mult_start), 64'd0);
        @(negedge clk);
        chk("start_n1", 64'(mult_start), 64'd1);
        @(negedge clk);
        chk("start_n2", 64'(mult_start), 64'd0);
        wait_result("single", 64'd67396319832108201);
        chk("single_one_start", 64'(n_starts - s0), 64'd1);

        // Masked operands and extremes.
        send(32'd59665, 32'd35353);
        wait_result("masked", 64'd2109336745);
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_result("max_max", 64'hFFFF_FFFE_0000_0001);
        send(32'h0, 32'hFFFF_FFFF);
        wait_result("zero_max", 64'd0);

        // Random jobs with random output backpressure.
        r0      = n_results;
        rnd_rdy = 1'b1;
        for (int i = 0; i < 12; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 4 == 1) ra = ra & 32'h0000_FFFF;
            send(ra, rb);
        end
        rnd_rdy = 1'b0;
        drain();
        chk("random_count", 64'(n_results - r0), 64'd12);

        // FIFO fill with output stalled: 4 in FIFO + 1 in flight.
        for (int i = 0; i < 6; i++) begin
            bp_a[i] = $urandom;
            bp_b[i] = $urandom;
        end
        out_ready = 1'b0;
        r0        = n_results;
        k         = 0;
        for (int c = 0; c < 30; c++) begin
            in_valid = (k < 6);
            in_a     = bp_a[k % 6];
            in_b     = bp_b[k % 6];
            @(negedge clk);
            if (in_valid && in_ready) k++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_accepted",  64'(k), 64'd5);
        chk("bp_in_ready",  64'(in_ready), 64'd0);
        chk("bp_out_valid", 64'(out_valid), 64'd1);
        chk("bp_first",     out_product, 64'(bp_a[0]) * 64'(bp_b[0]));
        @(posedge clk);
        #1;
        drain();
        chk("bp_count", 64'(n_results - r0), 64'd5);

        // Reset in WAIT_LO with another job queued.
        out_ready = 1'b1;
        send(32'hDEAD_BEEF, 32'h1234_5678);
        send(32'd77, 32'd88);
        bad = 1'b1;
        for (int i = 0; i < 50 && bad; i++) begin
            @(negedge clk);
            if (mult_busy) bad = 1'b0;
        end
        chk("rst_mid_busy_seen", 64'(bad), 64'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        r0  = n_results;
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid || mult_start) bad = 1'b1;
        end
        chk("rst_mid_quiet", 64'(bad), 64'd0);
        chk("rst_mid_no_result", 64'(n_results - r0), 64'd0);
        @(posedge clk);
        #1;
        send(32'd123456789, 32'd987654321);
        wait_result("after_rst", 64'd121932631112635269);

`ifdef MULT_SEQ_ACC_EN
        // Accumulator.
        drain();
        acc_clr = 1'b1;
        @(posedge clk);
        #1 acc_clr = 1'b0;
        send(32'd3, 32'd5);
        wait_result("acc_job1", 64'd15);
        send(32'd7, 32'd11);
        wait_result("acc_job2", 64'd77);
        @(negedge clk);
        chk("acc_sum", acc_out, 64'd92);
        @(posedge clk);
        #1 acc_clr = 1'b1;
        @(posedge clk);
        #1 acc_clr = 1'b0;
        @(negedge clk);
        chk("acc_clear", acc_out, 64'd0);
`endif

        drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mult32x32_seq
`default_nettype wire
